// File: rtl/dctq_mult_pkg.sv
// Shared helpers for the DCTQ quantiser multiplier: width/latency arithmetic,
// rounding/saturation mode codes and the side-band record carried along the pipe.
package dctq_mult_pkg;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << r) < value) begin
                r++;
            end
        end
        return r;
    endfunction

    function automatic int pad_width(input int w);
        return 1 << clog2(w);
    endfunction

    // One register for stage 1, two per tree level, one for round/saturate.
    function automatic int pipe_latency(input int b_w);
        return 2 * clog2(b_w) + 2;
    endfunction

    typedef enum logic {
        SAT_WRAP  = 1'b0,
        SAT_CLAMP = 1'b1
    } sat_mode_e;

    typedef enum logic {
        RND_TRUNC     = 1'b0,
        RND_HALF_AWAY = 1'b1
    } rnd_mode_e;

    typedef struct packed {
        logic valid;
        logic sign;
        logic zero;
    } sband_t;

endpackage

// File: rtl/mult_tree_level.sv
// One level of the partial-product adder tree: pairs of words are summed over
// two cycles, low halves first, then high halves plus the low-half carry.
module mult_tree_level
    import dctq_mult_pkg::*;
#(
    parameter int IN_W = 18,
    parameter int N_IN = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         ce,
    input  logic [N_IN*IN_W-1:0]         in_data,
    output logic [(N_IN/2)*IN_W-1:0]     out_data
);
    localparam int N_OUT = N_IN / 2;
    localparam int LO_W  = IN_W / 2;
    localparam int HI_W  = IN_W - LO_W;

    logic [N_IN-1:0][IN_W-1:0]  in_w;
    logic [N_OUT-1:0][LO_W:0]   lo_d, lo_q;
    logic [N_OUT-1:0][HI_W-1:0] hia_d, hia_q;
    logic [N_OUT-1:0][HI_W-1:0] hib_d, hib_q;
    logic [N_OUT-1:0][IN_W-1:0] sum_d, sum_q;

    assign in_w     = in_data;
    assign out_data = sum_q;

    always_comb begin
        lo_d  = '0;
        hia_d = '0;
        hib_d = '0;
        sum_d = '0;
        for (int i = 0; i < N_OUT; i++) begin
            lo_d[i]  = {1'b0, in_w[2*i][LO_W-1:0]} + {1'b0, in_w[2*i+1][LO_W-1:0]};
            hia_d[i] = in_w[2*i][IN_W-1:LO_W];
            hib_d[i] = in_w[2*i+1][IN_W-1:LO_W];
            // Magnitudes are bounded by the full product, so the high carry is never needed.
            sum_d[i] = {hia_q[i] + hib_q[i] + HI_W'(lo_q[i][LO_W]), lo_q[i][LO_W-1:0]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lo_q  <= '0;
            hia_q <= '0;
            hib_q <= '0;
            sum_q <= '0;
        end else if (ce) begin
            lo_q  <= lo_d;
            hia_q <= hia_d;
            hib_q <= hib_d;
            sum_q <= sum_d;
        end
    end

endmodule

// File: rtl/quant_mult_pipe.sv
// Pipelined signed x signed multiplier for the DCTQ quantiser: sign-magnitude
// partial-product tree, rounded right shift, symmetric saturation or wrap.
module quant_mult_pipe
    import dctq_mult_pkg::*;
#(
    parameter int A_W   = 11,
    parameter int B_W   = 8,
    parameter int SHIFT = 0,
    parameter int OUT_W = 19,
    parameter int SAT   = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ce,
    input  logic             in_valid,
    input  logic [A_W-1:0]   a,
    input  logic [B_W-1:0]   b,
    output logic             out_valid,
    output logic [OUT_W-1:0] result,
    output logic             ovf
);
    localparam int LVL        = clog2(B_W);
    localparam int P          = pad_width(B_W);
    localparam int LAT        = pipe_latency(B_W);
    localparam int PW         = A_W + B_W - 1;
    localparam int MW         = PW + 1;
    localparam int SB_D       = LAT - 1;
    localparam int TREE_WORDS = 2 * P - 1;
    localparam int RND_POS    = (SHIFT > 0) ? SHIFT - 1 : 0;

    localparam sat_mode_e SAT_MODE = (SAT != 0) ? SAT_CLAMP : SAT_WRAP;
    localparam rnd_mode_e RND_MODE = (SHIFT > 0) ? RND_HALF_AWAY : RND_TRUNC;

    localparam logic [OUT_W-1:0] POS_CLAMP = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W-1:0] NEG_CLAMP = ~POS_CLAMP + OUT_W'(1);
    localparam logic [MW-1:0]    MAX_MAG   = MW'(POS_CLAMP);
    localparam logic [MW-1:0]    RND_ADD   = (RND_MODE == RND_HALF_AWAY) ? (MW'(1) << RND_POS) : '0;

    genvar gi;

    // Stage 1: magnitudes and partial products
    logic [A_W-1:0]           a_mag;
    logic [B_W-1:0]           b_mag;
    logic [P-1:0][PW-1:0]     pp_d, pp_q;
    sband_t [SB_D-1:0]        sb_d, sb_q;

    assign a_mag = a[A_W-1] ? (~a + A_W'(1)) : a;
    assign b_mag = b[B_W-1] ? (~b + B_W'(1)) : b;

    generate
        for (gi = 0; gi < P; gi++) begin : g_pp
            if (gi < B_W) begin : g_live
                assign pp_d[gi] = b_mag[gi] ? (PW'(a_mag) << gi) : '0;
            end else begin : g_pad
                assign pp_d[gi] = '0;
            end
        end
    endgenerate

    always_comb begin
        sb_d    = sb_q;
        sb_d[0] = sband_t'({in_valid, a[A_W-1] ^ b[B_W-1], (a == '0) || (b == '0)});
        for (int k = 1; k < SB_D; k++) begin
            sb_d[k] = sb_q[k-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pp_q <= '0;
            sb_q <= '0;
        end else if (ce) begin
            pp_q <= pp_d;
            sb_q <= sb_d;
        end
    end

    // Every tree level's words live in one triangular bus; level k starts at word 2P-2*(P>>k).
    logic [TREE_WORDS*PW-1:0] tree_w;
    assign tree_w[P*PW-1:0] = pp_q;

    generate
        for (gi = 0; gi < LVL; gi++) begin : g_lvl
            localparam int N_IN    = P >> gi;
            localparam int IN_OFS  = 2 * P - 2 * N_IN;
            localparam int OUT_OFS = IN_OFS + N_IN;
            mult_tree_level #(
                .IN_W (PW),
                .N_IN (N_IN)
            ) u_level (
                .clk      (clk),
                .rst      (rst),
                .ce       (ce),
                .in_data  (tree_w[IN_OFS*PW +: N_IN*PW]),
                .out_data (tree_w[OUT_OFS*PW +: (N_IN/2)*PW])
            );
        end
    endgenerate

    // Final stage: round half away from zero on the magnitude, re-apply sign, saturate or wrap
    logic [PW-1:0]    mag;
    logic [MW-1:0]    mag_rnd;
    logic [OUT_W-1:0] signed_val;
    logic             over;
    sband_t           sb_last;
    logic             out_valid_d, out_valid_q;
    logic [OUT_W-1:0] result_d, result_q;
    logic             ovf_d, ovf_q;

    assign mag     = tree_w[(TREE_WORDS-1)*PW +: PW];
    assign sb_last = sb_q[SB_D-1];

    always_comb begin
        mag_rnd     = ({1'b0, mag} + RND_ADD) >> SHIFT;
        over        = (mag_rnd > MAX_MAG);
        signed_val  = sb_last.sign ? (~mag_rnd[OUT_W-1:0] + OUT_W'(1)) : mag_rnd[OUT_W-1:0];
        result_d    = signed_val;
        ovf_d       = over;
        out_valid_d = sb_last.valid;
        if (sb_last.zero) begin
            result_d = '0;
            ovf_d    = 1'b0;
        end else if (over && (SAT_MODE == SAT_CLAMP)) begin
            result_d = sb_last.sign ? NEG_CLAMP : POS_CLAMP;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            result_q    <= '0;
            ovf_q       <= 1'b0;
        end else if (ce) begin
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            ovf_q       <= ovf_d;
        end
    end

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_quant_mult_pipe.sv
// Bench for quant_mult_pipe: four parameterisations share one stimulus stream and
// are checked against an integer-arithmetic model of the signed rounded product.
module tb_quant_mult_pipe;

    localparam int LAT  = 8;
    localparam int HIST = 4096;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, ce, in_valid;
    logic [10:0] a;
    logic [7:0]  b;

    logic        v_def, v_shf, v_sat, v_wrp;
    logic [18:0] r_def;
    logic [14:0] r_shf;
    logic [11:0] r_sat, r_wrp;
    logic        o_def, o_shf, o_sat, o_wrp;

    quant_mult_pipe u_def (
        .clk(clk), .rst(rst), .ce(ce), .in_valid(in_valid), .a(a), .b(b),
        .out_valid(v_def), .result(r_def), .ovf(o_def)
    );

    quant_mult_pipe #(.SHIFT(4), .OUT_W(15)) u_shf (
        .clk(clk), .rst(rst), .ce(ce), .in_valid(in_valid), .a(a), .b(b),
        .out_valid(v_shf), .result(r_shf), .ovf(o_shf)
    );

    quant_mult_pipe #(.OUT_W(12), .SAT(1)) u_sat (
        .clk(clk), .rst(rst), .ce(ce), .in_valid(in_valid), .a(a), .b(b),
        .out_valid(v_sat), .result(r_sat), .ovf(o_sat)
    );

    quant_mult_pipe #(.OUT_W(12), .SAT(0)) u_wrp (
        .clk(clk), .rst(rst), .ce(ce), .in_valid(in_valid), .a(a), .b(b),
        .out_valid(v_wrp), .result(r_wrp), .ovf(o_wrp)
    );

    int     n_vec    = 0;
    int     n_bad    = 0;
    int     n_ce     = 0;
    int     rst_mark = 0;
    bit     hv [HIST];
    longint ha [HIST];
    longint hb [HIST];

    // Exact product, magnitude rounded half away from zero, then clamp or wrap to out_w bits.
    function automatic void ref_mult(input longint av, input longint bv, input int out_w,
                                     input int shift, input bit sat,
                                     output longint r, output bit o);
        longint p, m, maxp;
        p = av * bv;
        m = (p < 0) ? -p : p;
        if (shift > 0) m = (m + (longint'(1) << (shift - 1))) >> shift;
        maxp = (longint'(1) << (out_w - 1)) - 1;
        o = (m > maxp);
        if (av == 0 || bv == 0) begin
            r = 0;
            o = 1'b0;
        end else if (o && sat) begin
            r = (p < 0) ? -maxp : maxp;
        end else begin
            r = (p < 0) ? -m : m;
        end
        r = r & ((longint'(1) << out_w) - 1);
    endfunction

    function automatic longint pick(input int w);
        longint lo, hi;
        lo = -(longint'(1) << (w - 1));
        hi = (longint'(1) << (w - 1)) - 1;
        case ($urandom_range(7))
            0:       return lo;
            1:       return hi;
            2:       return 0;
            3:       return -1;
            default: return lo + longint'($urandom_range(32'(hi - lo)));
        endcase
    endfunction

    task automatic check_one(input string tag, input logic ov, input logic [31:0] res,
                             input logic of, input int out_w, input int shift,
                             input bit sat, input bit rst_now, input bit show);
        int     idx;
        bit     ev;
        longint er;
        bit     eo;
        logic [31:0] er_bits;
        idx = n_ce - LAT + 1;
        ev  = (idx > rst_mark) ? hv[idx] : 1'b0;
        n_vec++;
        assert (ov === ev) else begin
            n_bad++;
            $error("FAIL %s.out_valid obs=%0b exp=%0b", tag, ov, ev);
        end
        if (rst_now) begin
            n_vec++;
            assert (res === 32'd0) else begin
                n_bad++;
                $error("FAIL %s.rst_result obs=%0h exp=0", tag, res);
            end
            n_vec++;
            assert (of === 1'b0) else begin
                n_bad++;
                $error("FAIL %s.rst_ovf obs=%0b exp=0", tag, of);
            end
        end else if (ev) begin
            ref_mult(ha[idx], hb[idx], out_w, shift, sat, er, eo);
            er_bits = er[31:0];
            n_vec++;
            assert (res === er_bits) else begin
                n_bad++;
                $error("FAIL %s.result a=%0d b=%0d obs=%0h exp=%0h", tag, ha[idx], hb[idx], res, er_bits);
            end
            n_vec++;
            assert (of === eo) else begin
                n_bad++;
                $error("FAIL %s.ovf a=%0d b=%0d obs=%0b exp=%0b", tag, ha[idx], hb[idx], of, eo);
            end
            if (show) $display("txn a=%0d b=%0d result=%0h ovf=%0b", ha[idx], hb[idx], res, of);
        end
    endtask

    task automatic step();
        bit rst_now;
        @(posedge clk);
        rst_now = rst;
        if (rst) begin
            rst_mark = n_ce;
        end else if (ce) begin
            n_ce++;
            hv[n_ce] = in_valid;
            ha[n_ce] = longint'($signed(a));
            hb[n_ce] = longint'($signed(b));
        end
        #1;
        check_one("def", v_def, 32'(r_def), o_def, 19, 0, 1'b1, rst_now, 1'b1);
        check_one("shf", v_shf, 32'(r_shf), o_shf, 15, 4, 1'b1, rst_now, 1'b0);
        check_one("sat", v_sat, 32'(r_sat), o_sat, 12, 0, 1'b1, rst_now, 1'b0);
        check_one("wrp", v_wrp, 32'(r_wrp), o_wrp, 12, 0, 1'b0, rst_now, 1'b0);
    endtask

    task automatic drive(input bit v, input longint av, input longint bv, input bit c);
        in_valid = v;
        a        = 11'(av);
        b        = 8'(bv);
        ce       = c;
        step();
    endtask

    longint dir_a [16] = '{-1024, 0, -7, 25, -24, 23, -8, 1000, -1000, 10, 1023, -1024, 1023, -1, 511, -512};
    longint dir_b [16] = '{-128, -5, 0, 1, 1, 1, 1, 100, 100, 10, 127, 127, -128, -1, -128, 3};

    initial begin
        rst = 1'b1; ce = 1'b1; in_valid = 1'b0; a = '0; b = '0;
        step();
        step();
        rst = 1'b0;

        // Directed corner vectors back to back, then flush.
        for (int i = 0; i < 16; i++) drive(1'b1, dir_a[i], dir_b[i], 1'b1);
        repeat (LAT + 2) drive(1'b0, 0, 0, 1'b1);

        // Stream 1..20 x -3 with a 3-cycle stall carrying junk inputs.
        for (int i = 1; i <= 20; i++) begin
            if (i == 10) repeat (3) drive(1'b1, 99, 99, 1'b0);
            drive(1'b1, i, -3, 1'b1);
        end
        repeat (LAT + 2) drive(1'b0, 0, 0, 1'b1);

        // Random traffic with random bubbles and stalls.
        for (int i = 0; i < 400; i++)
            drive($urandom_range(3) != 0, pick(11), pick(8), $urandom_range(6) != 0);

        // One-cycle reset mid-stream, with ce low to show reset wins.
        for (int i = 0; i < 30; i++) drive(1'b1, pick(11), pick(8), 1'b1);
        rst = 1'b1;
        drive(1'b1, pick(11), pick(8), 1'b0);
        rst = 1'b0;
        for (int i = 0; i < 40; i++)
            drive($urandom_range(1) != 0, pick(11), pick(8), $urandom_range(4) != 0);
        repeat (3 * LAT) drive(1'b0, 0, 0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
